// File: rtl/pse_sort_ctrl.sv
// pse_sort_ctrl: loads 3-6 points, bubble-sorts slots 1..N-1 counter-clockwise about slot 0, streams them out.
// Define PSE_EARLY_EXIT_EN to end SORT after the first pass that makes no swap.
module pse_sort_ctrl #(
    parameter int W       = 10,
    parameter int MAX_PTS = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   Xin,
    input  logic [W-1:0]   Yin,
    input  logic [2:0]     point_num,
    output logic           valid,
    output logic [W-1:0]   Xout,
    output logic [W-1:0]   Yout,
    output logic [W-1:0]   cp_x0,
    output logic [W-1:0]   cp_y0,
    output logic [W-1:0]   cp_x1,
    output logic [W-1:0]   cp_y1,
    output logic [W-1:0]   cp_x2,
    output logic [W-1:0]   cp_y2,
    input  logic [2*W:0]   cp_out
);
    typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;
    state_t state, nstate;
    logic [W-1:0] sx [MAX_PTS];
    logic [W-1:0] sy [MAX_PTS];
    logic [W-1:0] hx0, hy0, hx1, hy1, hx2, hy2;
    logic [W-1:0] ox, oy;
    logic [2:0]   n, i, i1, p, nc, nn;
    logic         neg, last_i, sort_done;
`ifdef PSE_EARLY_EXIT_EN
    logic         swp;
`endif
    assign nc     = point_num > 3'(MAX_PTS) ? 3'(MAX_PTS) : point_num;
    assign nn     = nc == 3'd0 ? 3'd1 : nc;
    assign i1     = i + 3'd1;
    assign neg    = $signed(cp_out) < 0;
    assign last_i = i == n - 3'd2;
`ifdef PSE_EARLY_EXIT_EN
    assign sort_done = last_i && (p == n - 3'd3 || !(swp || neg));
`else
    assign sort_done = last_i && p == n - 3'd3;
`endif
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nstate;
    end
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = nn == 3'd1 ? OUT : LOAD;
            LOAD:    if (i == n - 3'd1) nstate = n >= 3'd3 ? SORT : OUT;
            SORT:    if (sort_done) nstate = OUT;
            OUT:     if (i == n - 3'd1) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end
    // cp_* follow the live slots during SORT and otherwise hold the last compare
    always_comb begin
        cp_x0 = state == SORT ? sx[0]  : hx0;
        cp_y0 = state == SORT ? sy[0]  : hy0;
        cp_x1 = state == SORT ? sx[i]  : hx1;
        cp_y1 = state == SORT ? sy[i]  : hy1;
        cp_x2 = state == SORT ? sx[i1] : hx2;
        cp_y2 = state == SORT ? sy[i1] : hy2;
        ox    = state == OUT ? sx[i1] : state == IDLE ? Xin : sx[0];
        oy    = state == OUT ? sy[i1] : state == IDLE ? Yin : sy[0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            Xout  <= '0;
            Yout  <= '0;
            n     <= '0;
            i     <= '0;
            p     <= '0;
            hx0   <= '0;
            hy0   <= '0;
            hx1   <= '0;
            hy1   <= '0;
            hx2   <= '0;
            hy2   <= '0;
`ifdef PSE_EARLY_EXIT_EN
            swp   <= 1'b0;
`endif
        end else begin
            valid <= nstate == OUT;
            Xout  <= nstate == OUT ? ox : '0;
            Yout  <= nstate == OUT ? oy : '0;
            case (state)
                IDLE: begin
                    sx[0] <= Xin;
                    sy[0] <= Yin;
                    n     <= nn;
                    i     <= nstate == OUT ? 3'd0 : 3'd1;
                end
                LOAD: begin
                    sx[i] <= Xin;
                    sy[i] <= Yin;
                    i     <= nstate == LOAD ? i1 : nstate == SORT ? 3'd1 : 3'd0;
                    p     <= '0;
`ifdef PSE_EARLY_EXIT_EN
                    swp   <= 1'b0;
`endif
                end
                SORT: begin
                    hx0 <= sx[0];
                    hy0 <= sy[0];
                    hx1 <= sx[i];
                    hy1 <= sy[i];
                    hx2 <= sx[i1];
                    hy2 <= sy[i1];
                    if (neg) begin
                        sx[i]  <= sx[i1];
                        sy[i]  <= sy[i1];
                        sx[i1] <= sx[i];
                        sy[i1] <= sy[i];
                    end
                    i <= sort_done ? 3'd0 : last_i ? 3'd1 : i1;
                    p <= last_i ? p + 3'd1 : p;
`ifdef PSE_EARLY_EXIT_EN
                    swp <= !last_i && (swp || neg);
`endif
                end
                OUT:     i <= i1;
                default: i <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_pse_sort_ctrl.sv
// tb_pse_sort_ctrl: directed sets through pse_sort_ctrl with a behavioural cross-product unit.
module tb_pse_sort_ctrl;
    localparam int W = 10;
    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   Xin, Yin;
    logic [2:0]     point_num;
    logic           valid;
    logic [W-1:0]   Xout, Yout, cp_x0, cp_y0, cp_x1, cp_y1, cp_x2, cp_y2;
    logic [2*W:0]   cp_out;
    int n_cmp = 0;
    int n_bad = 0;
    int px [8];
    int py [8];
    int ex [8];
    int ey [8];
    int gx [8];
    int gy [8];
    int s_sorted4, s_sorted6;

    pse_sort_ctrl #(.W(W), .MAX_PTS(6)) dut (
        .clk(clk), .reset(reset), .Xin(Xin), .Yin(Yin), .point_num(point_num),
        .valid(valid), .Xout(Xout), .Yout(Yout),
        .cp_x0(cp_x0), .cp_y0(cp_y0), .cp_x1(cp_x1), .cp_y1(cp_y1),
        .cp_x2(cp_x2), .cp_y2(cp_y2), .cp_out(cp_out)
    );

    always #5 clk = ~clk;

    always_comb
        cp_out = (2*W+1)'((int'(cp_x1) - int'(cp_x0)) * (int'(cp_y2) - int'(cp_y0))
                        - (int'(cp_x2) - int'(cp_x0)) * (int'(cp_y1) - int'(cp_y0)));

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Starts on a load-cycle-0 negedge and returns on the next set's load-cycle-0 negedge
    task automatic run_set(input string tag, input int nreq, input int nexp, input int sexp);
        int gaps;
        for (int k = 0; k < nexp; k++) begin
            Xin = W'(px[k]);
            Yin = W'(py[k]);
            point_num = k == 0 ? 3'(nreq) : 3'd7;
            @(negedge clk);
        end
        gaps = 0;
        while (!valid && gaps < 40) begin
            gaps++;
            @(negedge clk);
        end
        check({tag, " sort_cycles"}, gaps, sexp);
        for (int k = 0; k < nexp; k++) begin
            check($sformatf("%s valid[%0d]", tag, k), int'(valid), 1);
            check($sformatf("%s x[%0d]", tag, k), int'(Xout), ex[k]);
            check($sformatf("%s y[%0d]", tag, k), int'(Yout), ey[k]);
            gx[k] = int'(Xout);
            gy[k] = int'(Yout);
            @(negedge clk);
        end
        check({tag, " valid_end"}, int'(valid), 0);
        check({tag, " xout_end"}, int'(Xout), 0);
    endtask

    initial begin
`ifdef PSE_EARLY_EXIT_EN
        s_sorted4 = 2;
        s_sorted6 = 4;
`else
        s_sorted4 = 4;
        s_sorted6 = 16;
`endif
        reset = 1'b1;
        Xin = '0;
        Yin = '0;
        point_num = '0;
        repeat (2) @(negedge clk);
        check("rst valid", int'(valid), 0);
        check("rst xout", int'(Xout), 0);
        check("rst yout", int'(Yout), 0);
        check("rst cp_x1", int'(cp_x1), 0);
        check("rst cp_y2", int'(cp_y2), 0);
        reset = 1'b0;

        px = '{0, 0, 10, 0, 0, 0, 0, 0};    py = '{0, 10, 0, 0, 0, 0, 0, 0};
        ex = '{0, 10, 0, 0, 0, 0, 0, 0};    ey = '{0, 0, 10, 0, 0, 0, 0, 0};
        run_set("n3_swap", 3, 3, 1);

        px = '{100, 80, 100, 120, 140, 150, 0, 0};  py = '{100, 140, 150, 140, 120, 100, 0, 0};
        ex = '{100, 150, 140, 120, 100, 80, 0, 0};  ey = '{100, 100, 120, 140, 150, 140, 0, 0};
        run_set("n6_cw", 6, 6, 16);
        for (int a = 1; a < 6; a++)
            for (int b = a + 1; b < 6; b++)
                check($sformatf("n6_ccw(%0d,%0d)", a, b),
                      int'((gx[a] - gx[0]) * (gy[b] - gy[0]) - (gx[b] - gx[0]) * (gy[a] - gy[0]) >= 0), 1);

        px = '{0, 10, 10, 0, 0, 0, 0, 0};   py = '{0, 0, 10, 10, 0, 0, 0, 0};
        ex = px;                            ey = py;
        run_set("n4_sorted", 4, 4, s_sorted4);

        px = '{100, 150, 140, 120, 100, 80, 0, 0};  py = '{100, 100, 120, 140, 150, 140, 0, 0};
        ex = px;                                    ey = py;
        run_set("n7_clamp", 7, 6, s_sorted6);

        px = '{3, 7, 0, 0, 0, 0, 0, 0};     py = '{4, 1, 0, 0, 0, 0, 0, 0};
        ex = px;                            ey = py;
        run_set("n2", 2, 2, 0);

        px = '{9, 0, 0, 0, 0, 0, 0, 0};     py = '{8, 0, 0, 0, 0, 0, 0, 0};
        ex = px;                            ey = py;
        run_set("n0", 0, 1, 0);

        px = '{0, 5, 2, 0, 0, 0, 0, 0};     py = '{0, 5, 2, 0, 0, 0, 0, 0};
        ex = px;                            ey = py;
        run_set("collinear", 3, 3, 1);

        px = '{100, 80, 100, 120, 140, 150, 0, 0};  py = '{100, 140, 150, 140, 120, 100, 0, 0};
        for (int k = 0; k < 6; k++) begin
            Xin = W'(px[k]);
            Yin = W'(py[k]);
            point_num = k == 0 ? 3'd6 : 3'd7;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort valid", int'(valid), 0);
        check("abort xout", int'(Xout), 0);
        check("abort yout", int'(Yout), 0);
        check("abort cp_x1", int'(cp_x1), 0);

        px = '{1, 1, 5, 0, 0, 0, 0, 0};     py = '{1, 5, 1, 0, 0, 0, 0, 0};
        ex = '{1, 5, 1, 0, 0, 0, 0, 0};     ey = '{1, 1, 5, 0, 0, 0, 0, 0};
        run_set("after_abort", 3, 3, 1);

        px = '{0, 0, 10, 0, 0, 0, 0, 0};    py = '{0, 10, 0, 0, 0, 0, 0, 0};
        ex = '{0, 10, 0, 0, 0, 0, 0, 0};    ey = '{0, 0, 10, 0, 0, 0, 0, 0};
        run_set("back_to_back", 3, 3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
